// File: rtl/dma_scheduler_pkg.sv
// Shared types and default sizing for the DMA request scheduler.
// The state enum is common to the scheduler and anything that observes its FSM.
package dma_sched_pkg;

  localparam int DEF_NUM_REQ = 32'sd2;
  localparam int DEF_TIMEOUT = 32'sd256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } dma_state_e;

endpackage

// File: rtl/dma_scheduler_if.sv
// Requester and DMA-side signal bundle of the scheduler.
// The slave modport is the scheduler's view; master is the environment's view.
interface dma_scheduler_if
  import dma_sched_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int NUM_REQ = DEF_NUM_REQ
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic [NUM_REQ-1:0]                 req;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_rom_addr;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_ram_addr;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_amt;
  logic [NUM_REQ-1:0]                 ack;
  logic [NUM_REQ-1:0]                 req_done;
  logic                               timeout_err;
  logic                               start_dma;
  logic [ADDR_WIDTH-1:0]              starting_rom;
  logic [ADDR_WIDTH-1:0]              starting_ram;
  logic [ADDR_WIDTH-1:0]              data_amt;
  logic                               dma_done;
  logic                               busy;

  modport slave (
    input  req, req_rom_addr, req_ram_addr, req_amt, dma_done,
    output ack, req_done, timeout_err, start_dma,
           starting_rom, starting_ram, data_amt, busy
  );

  modport master (
    output req, req_rom_addr, req_ram_addr, req_amt, dma_done,
    input  ack, req_done, timeout_err, start_dma,
           starting_rom, starting_ram, data_amt, busy
  );

endinterface

// File: rtl/dma_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search begins just after last_grant,
// so the most recently served requester has the lowest priority.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
  localparam int IDX_WIDTH = $clog2(NUM_REQ);
  localparam int SW        = IDX_WIDTH + 1;

  logic [SW-1:0]        sum_s;
  logic [IDX_WIDTH-1:0] cand_s;
  logic                 found_s;

  // Scan candidates (last_grant+1 .. last_grant+NUM_REQ) mod NUM_REQ, first hit wins
  always_comb begin
    grant     = {NUM_REQ{1'b0}};
    grant_idx = {IDX_WIDTH{1'b0}};
    found_s   = 1'b0;
    sum_s     = {SW{1'b0}};
    cand_s    = {IDX_WIDTH{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum_s = {1'b0, last_grant} + SW'(i);
      if (sum_s >= SW'(NUM_REQ)) begin
        sum_s = sum_s - SW'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IDX_WIDTH-1:0];
      if (!found_s && req[cand_s]) begin
        grant[cand_s] = 1'b1;
        grant_idx     = cand_s;
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/dma_scheduler.sv
// Shares one DMA engine among NUM_REQ requesters: arbitrates, latches the
// winner's transfer config, starts the DMA and reports completion or timeout.
module dma_scheduler
  import dma_sched_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           reset,
  dma_scheduler_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int IDX_WIDTH  = $clog2(NUM_REQ);
  localparam int CNT_WIDTH  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_REQ - 1);

  dma_state_e            state_r, state_nxt_s;
  logic [NUM_REQ-1:0]    arb_grant_s, grant_oh_r, ack_r, req_done_r;
  logic [IDX_WIDTH-1:0]  arb_idx_s, grant_idx_r, last_grant_r;
  logic [CNT_WIDTH-1:0]  cnt_r, cnt_nxt_s;
  logic                  err_r, err_nxt_s;
  logic                  timeout_err_r, start_dma_r, busy_r;
  logic [ADDR_WIDTH-1:0] rom_r, ram_r, amt_r;
  logic                  take_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (bus.req),
    .last_grant (last_grant_r),
    .grant      (arb_grant_s),
    .grant_idx  (arb_idx_s)
  );

  assign take_s = (state_r == ST_IDLE) && (|bus.req);

  // Next-state, timeout counter and error-flag logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    err_nxt_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        err_nxt_s = 1'b0;
        if (|bus.req) state_nxt_s = ST_LATCH;
        else          state_nxt_s = ST_IDLE;
      end
      ST_LATCH: begin
        if (amt_r != {ADDR_WIDTH{1'b0}}) state_nxt_s = ST_START;
        else                             state_nxt_s = ST_DONE;
      end
      ST_START: begin
        state_nxt_s = ST_WAIT;
        cnt_nxt_s   = {CNT_WIDTH{1'b0}};
      end
      ST_WAIT: begin
        // A done arriving on the last allowed cycle still counts as success
        if (bus.dma_done) begin
          state_nxt_s = ST_DONE;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DONE;
          err_nxt_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, registered pulses and latched transfer config
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CNT_WIDTH{1'b0}};
      err_r         <= 1'b0;
      ack_r         <= {NUM_REQ{1'b0}};
      req_done_r    <= {NUM_REQ{1'b0}};
      timeout_err_r <= 1'b0;
      start_dma_r   <= 1'b0;
      busy_r        <= 1'b0;
      grant_oh_r    <= {NUM_REQ{1'b0}};
      grant_idx_r   <= {IDX_WIDTH{1'b0}};
      last_grant_r  <= IDX_LAST;
      rom_r         <= {ADDR_WIDTH{1'b0}};
      ram_r         <= {ADDR_WIDTH{1'b0}};
      amt_r         <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      err_r         <= err_nxt_s;
      ack_r         <= (state_nxt_s == ST_LATCH) ? arb_grant_s : {NUM_REQ{1'b0}};
      req_done_r    <= (state_nxt_s == ST_DONE) ? grant_oh_r : {NUM_REQ{1'b0}};
      timeout_err_r <= (state_nxt_s == ST_DONE) && err_nxt_s;
      start_dma_r   <= (state_nxt_s == ST_START);
      busy_r        <= (state_nxt_s != ST_IDLE);
      if (take_s) begin
        grant_oh_r  <= arb_grant_s;
        grant_idx_r <= arb_idx_s;
        rom_r       <= bus.req_rom_addr[arb_idx_s];
        ram_r       <= bus.req_ram_addr[arb_idx_s];
        amt_r       <= bus.req_amt[arb_idx_s];
      end
      if (state_r == ST_LATCH) begin
        last_grant_r <= grant_idx_r;
      end
    end
  end

  assign bus.ack          = ack_r;
  assign bus.req_done     = req_done_r;
  assign bus.timeout_err  = timeout_err_r;
  assign bus.start_dma    = start_dma_r;
  assign bus.busy         = busy_r;
  assign bus.starting_rom = rom_r;
  assign bus.starting_ram = ram_r;
  assign bus.data_amt     = amt_r;

endmodule
